// File: rtl/vga_tile_pkg.sv
// Shared types, fixed colours, tile palette and default 640x480 timing
// for the tile-board display.
package vga_tile_pkg;

    typedef logic [23:0] rgb_t;

    localparam rgb_t BG_COLOR    = 24'h202020;
    localparam rgb_t GRID_COLOR  = 24'h808080;
    localparam rgb_t EMPTY_COLOR = 24'hC0B4A0;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Tile exponent to fill colour; 0 is an empty cell, k stands for 2^k.
    function automatic rgb_t palette(input logic [7:0] exp_val);
        rgb_t c;
        case (exp_val)
            8'd0:    c = EMPTY_COLOR;
            8'd1:    c = 24'hEEE4DA;
            8'd2:    c = 24'hEDE0C8;
            8'd3:    c = 24'hF2B179;
            8'd4:    c = 24'hF59563;
            8'd5:    c = 24'hF67C5F;
            8'd6:    c = 24'hF65E3B;
            8'd7:    c = 24'hEDCF72;
            8'd8:    c = 24'hEDCC61;
            8'd9:    c = 24'hEDC850;
            8'd10:   c = 24'hEDC53F;
            8'd11:   c = 24'hEDC22E;
            8'd12:   c = 24'h3C3A32;
            8'd13:   c = 24'h5A5A50;
            8'd14:   c = 24'h787064;
            8'd15:   c = 24'h1E1E1E;
            default: c = 24'h3C3A32;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider, horizontal/vertical counters and the raw
// (undelayed) sync and active-area flags derived from them.
module vga_timing_gen
    import vga_tile_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HC_W     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VC_W     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            p_tick,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic            line_end,
    output logic            hs_on,
    output logic            vs_on,
    output logic            active
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // With CLK_DIV=1 the count is pinned at 0 and p_tick stays high.
    assign p_tick   = (div_cnt == DIV_LAST);
    assign line_end = (int'(hc) == H_TOTAL - 1);

    // Divider: count up to CLK_DIV-1, strobe, wrap.
    always_ff @(posedge clk) begin
        if (reset)       div_cnt <= '0;
        else if (p_tick) div_cnt <= '0;
        else             div_cnt <= div_cnt + 1'b1;
    end

    // Raster counters advance once per pixel; vc steps when hc wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (p_tick) begin
            if (line_end) begin
                hc <= '0;
                if (int'(vc) == V_TOTAL - 1) vc <= '0;
                else                         vc <= vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    // Active-high pulse flags; the top inverts them at the output stage.
    assign hs_on  = (int'(hc) >= H_ACTIVE + H_FP) && (int'(hc) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_on  = (int'(vc) >= V_ACTIVE + V_FP) && (int'(vc) < V_ACTIVE + V_FP + V_SYNC);
    assign active = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);

endmodule

// File: rtl/vga_tile_board.sv
// Tile-grid renderer: double-buffered board, commit/vblank swap, tile
// tracking and a two-stage colour pipeline with delay-matched syncs.
//
// Write handshake: a shadow write is taken on any clock edge where
// wr_valid && wr_ready; wr_ready is low exactly while a commit is pending,
// and wr_row/wr_col/wr_val only need to be stable in that cycle.
module vga_tile_board
    import vga_tile_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int BOARD_N  = 4,
    parameter int VAL_W    = 4,
    parameter int TILE_PX  = 100,
    parameter int GAP      = 4,
    parameter int X0       = 120,
    parameter int Y0       = 40
) (
    input  logic                       clk_50MHz,
    input  logic                       reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(BOARD_N)-1:0] wr_row,
    input  logic [$clog2(BOARD_N)-1:0] wr_col,
    input  logic [VAL_W-1:0]           wr_val,
    input  logic                       commit,
    output logic                       commit_pending,
    output logic                       swap_done,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       blank,
    output logic                       sync,
    output logic                       p_tick,
    output logic                       frame_start,
    output logic [23:0]                rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int PX_W    = $clog2(TILE_PX);
    localparam int TX_W    = $clog2(BOARD_N);
    localparam int SPAN    = BOARD_N * TILE_PX;
    // Counter values one pixel/line before the board edge, where the
    // tile trackers are re-armed so they read 0 exactly at X0/Y0.
    localparam int X_PRE   = (X0 == 0) ? H_TOTAL - 1 : X0 - 1;
    localparam int Y_PRE   = (Y0 == 0) ? V_TOTAL - 1 : Y0 - 1;

    logic [HC_W-1:0]  hc;
    logic [VC_W-1:0]  vc;
    logic             line_end, hs_on, vs_on, active;
    logic [PX_W-1:0]  px, py;
    logic [TX_W-1:0]  tx, ty;
    logic             in_board, swap_now;
    logic [VAL_W-1:0] shadow_buf [BOARD_N][BOARD_N];
    logic [VAL_W-1:0] act_buf    [BOARD_N][BOARD_N];
    logic             s1_active, s1_board, s1_grid, s1_hs, s1_vs;
    logic [VAL_W-1:0] s1_val;
    rgb_t             pix;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),  .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC),
        .H_BP    (H_BP),     .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC),
        .V_BP    (V_BP),     .HC_W    (HC_W),     .VC_W(VC_W)
    ) u_timing (
        .clk     (clk_50MHz), .reset (reset),  .p_tick(p_tick), .hc(hc), .vc(vc),
        .line_end(line_end),  .hs_on (hs_on),  .vs_on (vs_on),  .active(active)
    );

    assign sync           = 1'b0;
    assign wr_ready       = !commit_pending;
    assign frame_start    = p_tick && (hc == '0) && (vc == '0);
    assign swap_now       = p_tick && (hc == '0) && (int'(vc) == V_ACTIVE) && commit_pending;
    assign swap_done      = swap_now;
    assign in_board       = (int'(hc) >= X0) && (int'(hc) < X0 + SPAN)
                         && (int'(vc) >= Y0) && (int'(vc) < Y0 + SPAN);

    // Incremental tile trackers that run alongside hc/vc.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            px <= '0; tx <= '0; py <= '0; ty <= '0;
        end else if (p_tick) begin
            if (int'(hc) == X_PRE) begin
                px <= '0; tx <= '0;
            end else if (int'(px) == TILE_PX - 1) begin
                px <= '0; tx <= tx + 1'b1;
            end else begin
                px <= px + 1'b1;
            end
            if (line_end) begin
                if (int'(vc) == Y_PRE) begin
                    py <= '0; ty <= '0;
                end else if (int'(py) == TILE_PX - 1) begin
                    py <= '0; ty <= ty + 1'b1;
                end else begin
                    py <= py + 1'b1;
                end
            end
        end
    end

    // Board buffers and commit flag; the swap only happens on the first vblank line.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            for (int r = 0; r < BOARD_N; r++) begin
                for (int c = 0; c < BOARD_N; c++) begin
                    shadow_buf[r][c] <= '0;
                    act_buf[r][c]    <= '0;
                end
            end
            commit_pending <= 1'b0;
        end else begin
            if (wr_valid && wr_ready && (int'(wr_row) < BOARD_N) && (int'(wr_col) < BOARD_N))
                shadow_buf[wr_row][wr_col] <= wr_val;
            if (swap_now) begin
                act_buf        <= shadow_buf;
                commit_pending <= 1'b0;
            end else if (commit && !commit_pending) begin
                commit_pending <= 1'b1;
            end
        end
    end

    // Stage 1: classify the current pixel and fetch its tile exponent.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            s1_active <= 1'b0; s1_board <= 1'b0; s1_grid <= 1'b0;
            s1_hs     <= 1'b0; s1_vs    <= 1'b0; s1_val  <= '0;
        end else if (p_tick) begin
            s1_active <= active;
            s1_board  <= in_board;
            s1_grid   <= (int'(px) < GAP) || (int'(py) < GAP);
            s1_hs     <= hs_on;
            s1_vs     <= vs_on;
            s1_val    <= in_board ? act_buf[ty][tx] : '0;
        end
    end

    // Colour selection, first matching rule wins.
    always_comb begin
        pix = '0;
        if (!s1_active)    pix = '0;
        else if (!s1_board) pix = BG_COLOR;
        else if (s1_grid)   pix = GRID_COLOR;
        else                pix = palette(8'(s1_val));
    end

    // Stage 2: registered DAC outputs, syncs delayed alongside colour.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            rgb   <= '0;
            blank <= 1'b0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (p_tick) begin
            rgb   <= pix;
            blank <= s1_active;
            hsync <= !s1_hs;
            vsync <= !s1_vs;
        end
    end

endmodule
